// File: rtl/apb_i2c_bridge_pkg.sv
// Shared types and constants for the APB-to-I2C bridge and the I2C block.
// The address byte is split into a device id (upper bits) and a memory address.
package apb_i2c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } bridge_state_t;

  localparam int DEV_ID_W   = 2;
  localparam int MEM_ADDR_W = 6;

  // Read data returned to the APB master when the I2C block never answers
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

  // Device id field of an address byte
  function automatic logic [DEV_ID_W-1:0] dev_id(input logic [DEV_ID_W+MEM_ADDR_W-1:0] a);
    return a[DEV_ID_W+MEM_ADDR_W-1:MEM_ADDR_W];
  endfunction

  // Memory address field of an address byte
  function automatic logic [MEM_ADDR_W-1:0] mem_addr(input logic [DEV_ID_W+MEM_ADDR_W-1:0] a);
    return a[MEM_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/apb_i2c_bridge_if.sv
// APB slave bus plus the I2C request bus seen by the bridge.
// slave: the bridge's view; master: the APB master / I2C block side (testbench).
interface apb_i2c_bridge_if;
  import apb_i2c_pkg::*;

  localparam int ADDR_W = DEV_ID_W + MEM_ADDR_W;

  // APB side
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;

  // I2C request side
  logic              ce;
  logic              wren;
  logic              rden;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              error;
  logic              i2c_done;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, rdata, error, i2c_done,
    output prdata, pready, pslverr, ce, wren, rden, addr, wdata
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, rdata, error, i2c_done,
    input  prdata, pready, pslverr, ce, wren, rden, addr, wdata
  );

endinterface

// File: rtl/apb_i2c_bridge_timeout.sv
// Saturating transfer-timeout counter. Clear has priority over enable; the
// count stops at TIMEOUT_CYCLES-1, which is the expired condition.
module bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk8x,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max  = (r_cnt == CNT_MAX);
  assign o_expired = w_at_max;

  // Count cycles while enabled, never wrapping past the limit
  always_ff @(posedge clk8x or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_en && !w_at_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/apb_i2c_bridge.sv
// APB slave that forwards byte reads/writes to the I2C block and stalls the
// APB access phase until i2c_done or a timeout. All bus outputs are registered.
module apb_i2c_bridge
  import apb_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic             clk8x,
  input logic             reset_n,
  apb_i2c_bridge_if.slave bus
);

  bridge_state_t r_state, w_state_nxt;

  logic [7:0] r_prdata, w_prdata_nxt;
  logic       r_pready, w_pready_nxt;
  logic       r_pslverr, w_pslverr_nxt;
  logic       r_ce, w_ce_nxt;
  logic       r_wren, w_wren_nxt;
  logic       r_rden, w_rden_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;

  logic w_tmo_clr;
  logic w_tmo_en;
  logic w_tmo_expired;

  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk8x    (clk8x),
    .reset_n  (reset_n),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expired(w_tmo_expired)
  );

  // FSM state register
  always_ff @(posedge clk8x or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next registered outputs and timeout control
  always_comb begin
    w_state_nxt   = r_state;
    w_prdata_nxt  = r_prdata;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_ce_nxt      = r_ce;
    w_wren_nxt    = r_wren;
    w_rden_nxt    = r_rden;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_tmo_clr     = 1'b0;
    w_tmo_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          // Setup phase: latch the request and start the I2C transaction
          w_state_nxt = BUSY;
          w_ce_nxt    = 1'b1;
          w_wren_nxt  = bus.pwrite;
          w_rden_nxt  = !bus.pwrite;
          w_addr_nxt  = bus.paddr;
          w_wdata_nxt = bus.pwdata;
          w_tmo_clr   = 1'b1;
        end else if (bus.psel && bus.penable) begin
          // Access with no setup: answer with an error, never touch I2C
          w_state_nxt   = RESP;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        w_tmo_en = 1'b1;
        if (!bus.psel) begin
          // Master gave up: finish the I2C side quietly
          if (bus.i2c_done || w_tmo_expired) begin
            w_state_nxt = IDLE;
            w_ce_nxt    = 1'b0;
            w_wren_nxt  = 1'b0;
            w_rden_nxt  = 1'b0;
          end else begin
            w_state_nxt = DRAIN;
            w_tmo_clr   = 1'b1;
          end
        end else if (bus.i2c_done) begin
          // Completion wins over a timeout landing in the same cycle
          w_state_nxt   = RESP;
          w_ce_nxt      = 1'b0;
          w_wren_nxt    = 1'b0;
          w_rden_nxt    = 1'b0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = bus.error;
          if (r_rden) begin
            w_prdata_nxt = bus.rdata;
          end else begin
            w_prdata_nxt = r_prdata;
          end
        end else if (w_tmo_expired) begin
          w_state_nxt   = RESP;
          w_ce_nxt      = 1'b0;
          w_wren_nxt    = 1'b0;
          w_rden_nxt    = 1'b0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = 1'b1;
          w_prdata_nxt  = TIMEOUT_DATA;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      DRAIN: begin
        w_tmo_en = 1'b1;
        if (bus.i2c_done || w_tmo_expired) begin
          w_state_nxt = IDLE;
          w_ce_nxt    = 1'b0;
          w_wren_nxt  = 1'b0;
          w_rden_nxt  = 1'b0;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ce_nxt    = 1'b0;
        w_wren_nxt  = 1'b0;
        w_rden_nxt  = 1'b0;
      end
    endcase
  end

  // Registered APB and I2C outputs
  always_ff @(posedge clk8x or negedge reset_n) begin
    if (!reset_n) begin
      r_prdata  <= 8'h00;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_ce      <= 1'b0;
      r_wren    <= 1'b0;
      r_rden    <= 1'b0;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
    end else begin
      r_prdata  <= w_prdata_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_ce      <= w_ce_nxt;
      r_wren    <= w_wren_nxt;
      r_rden    <= w_rden_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
    end
  end

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
  assign bus.ce      = r_ce;
  assign bus.wren    = r_wren;
  assign bus.rden    = r_rden;
  assign bus.addr    = r_addr;
  assign bus.wdata   = r_wdata;

endmodule
